// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the three requesters' hold/access signals and the
// single BRAM port behind the arbiter.
//   i_req/i_acc/i_we  : per-requester hold request, access strobe, write qualifier
//   i_addr/i_wdata    : packed per-requester address (AW each) and write byte
//   o_gnt             : registered one-hot grant
//   o_rvalid/o_rdata  : per-requester read-valid pulse and shared read byte
//   o_timeout         : one-cycle pulse on forced revoke
//   o_mem_*           : BRAM port drive; i_mem_rdata returns one cycle after a read
// The slave modport belongs to the arbiter. The master modport belongs to the
// requester/BRAM side.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 10
);
  logic [2:0]      i_req;
  logic [2:0]      o_gnt;
  logic [2:0]      i_acc;
  logic [2:0]      i_we;
  logic [3*AW-1:0] i_addr;
  logic [23:0]     i_wdata;
  logic [2:0]      o_rvalid;
  logic [7:0]      o_rdata;
  logic            o_timeout;
  logic            o_mem_en;
  logic            o_mem_we;
  logic [AW-1:0]   o_mem_addr;
  logic [7:0]      o_mem_wdata;
  logic [7:0]      i_mem_rdata;

  modport slave (
    input  i_req, i_acc, i_we, i_addr, i_wdata, i_mem_rdata,
    output o_gnt, o_rvalid, o_rdata, o_timeout,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_req, i_acc, i_we, i_addr, i_wdata, i_mem_rdata,
    input  o_gnt, o_rvalid, o_rdata, o_timeout,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one BRAM port between three requesters. Requester 0 is
// the checksum engine, requester 1 is the frame writer and requester 2 is the
// frame sender.
// A requester holds i_req to own the port. The owner is chosen round-robin after
// the previous owner. While a requester owns the port, its access signals are
// muxed straight onto the BRAM pins.
// If the owner stays idle for TIMEOUT cycles, the grant is revoked. That
// requester is then blocked until it drops i_req.
//   i_clk, i_rst : rising-edge clock, asynchronous active-high reset
//   bus          : requester and BRAM signals (mem_port_arbiter_if.slave)
module mem_port_arbiter #(
  parameter int unsigned AW      = 10,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StGrant   = 2'd1;
  localparam logic [1:0] StRelease = 2'd2;

  localparam logic [9:0] TimeoutVal = 10'(TIMEOUT);

  logic [1:0] state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;
  logic [2:0] gnt_q, gnt_d;
  logic [2:0] blocked_q, blocked_d;
  logic [2:0] rvalid_q, rvalid_d;
  logic       timeout_q, timeout_d;
  logic [9:0] cnt_q, cnt_d;

  logic          own_req, own_acc, own_we;
  logic [AW-1:0] own_addr;
  logic [7:0]    own_wdata;
  logic          granted, mem_en, mem_we;
  logic [2:0]    eligible;
  logic [1:0]    pick;

  // Select the current owner's signals.
  always_comb begin
    own_req   = 1'b0;
    own_acc   = 1'b0;
    own_we    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    case (owner_q)
      2'd0: begin
        own_req   = bus.i_req[0];
        own_acc   = bus.i_acc[0];
        own_we    = bus.i_we[0];
        own_addr  = bus.i_addr[0 +: AW];
        own_wdata = bus.i_wdata[7:0];
      end
      2'd1: begin
        own_req   = bus.i_req[1];
        own_acc   = bus.i_acc[1];
        own_we    = bus.i_we[1];
        own_addr  = bus.i_addr[AW +: AW];
        own_wdata = bus.i_wdata[15:8];
      end
      2'd2: begin
        own_req   = bus.i_req[2];
        own_acc   = bus.i_acc[2];
        own_we    = bus.i_we[2];
        own_addr  = bus.i_addr[2*AW +: AW];
        own_wdata = bus.i_wdata[23:16];
      end
      default: ;
    endcase
  end

  // The BRAM is driven only in GRANT, and only while the owner still holds i_req.
  // Reset forces state_q to StIdle asynchronously, which drops the BRAM enable
  // in the same cycle.
  assign granted         = (state_q == StGrant);
  assign mem_en          = granted & own_req & own_acc;
  assign mem_we          = mem_en & own_we;
  assign bus.o_mem_en    = mem_en;
  assign bus.o_mem_we    = mem_we;
  assign bus.o_mem_addr  = (granted & own_req) ? own_addr : '0;
  assign bus.o_mem_wdata = (granted & own_req) ? own_wdata : '0;

  assign bus.o_gnt     = gnt_q;
  assign bus.o_rvalid  = rvalid_q;
  assign bus.o_timeout = timeout_q;
  assign bus.o_rdata   = bus.i_mem_rdata;

  // Round-robin: the search starts with the requester after last_q.
  always_comb begin
    eligible = bus.i_req & ~blocked_q;
    case (last_q)
      2'd0:    pick = eligible[1] ? 2'd1 : (eligible[2] ? 2'd2 : 2'd0);
      2'd1:    pick = eligible[2] ? 2'd2 : (eligible[0] ? 2'd0 : 2'd1);
      default: pick = eligible[0] ? 2'd0 : (eligible[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    // A block is lifted as soon as the blocked requester lets go of i_req.
    blocked_d = blocked_q & bus.i_req;
    rvalid_d  = '0;
    if (mem_en && !mem_we) begin
      rvalid_d = 3'b001 << owner_q;
    end
    case (state_q)
      StIdle: begin
        if (|eligible) begin
          state_d = StGrant;
          owner_d = pick;
          gnt_d   = 3'b001 << pick;
          cnt_d   = '0;
        end
      end
      StGrant: begin
        // A voluntary release takes priority over a timeout that lands in the same cycle.
        if (!own_req) begin
          state_d = StRelease;
          gnt_d   = '0;
          last_d  = owner_q;
        end else if (cnt_q == TimeoutVal) begin
          state_d   = StRelease;
          gnt_d     = '0;
          last_d    = owner_q;
          timeout_d = 1'b1;
          blocked_d = blocked_d | (3'b001 << owner_q);
        end else if (mem_en) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StIdle;
      owner_q   <= 2'd0;
      last_q    <= 2'd2;
      gnt_q     <= '0;
      blocked_q <= '0;
      rvalid_q  <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      blocked_q <= blocked_d;
      rvalid_q  <= rvalid_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. A reference model turns each cycle's stimulus into
// expected grant, timeout and BRAM-bus values, plus read responses. A monitor
// running on the falling edge compares these expectations against the DUT.
module tb_mem_port_arbiter;
  localparam int unsigned AW  = 10;
  localparam int unsigned TMO = 4;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;

  mem_port_arbiter_if #(.AW(AW)) bus ();

  mem_port_arbiter #(.AW(AW), .TIMEOUT(TMO)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial forever #5 i_clk = ~i_clk;

  // BRAM behaviour: synchronous write, registered read.
  logic [7:0] bram [1024];
  logic [7:0] bram_rd;
  always @(posedge i_clk) begin
    if (bus.o_mem_en) begin
      if (bus.o_mem_we) bram[bus.o_mem_addr] <= bus.o_mem_wdata;
      else              bram_rd <= bram[bus.o_mem_addr];
    end
  end
  assign bus.i_mem_rdata = bram_rd;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endfunction

  typedef struct {
    logic [2:0]     gnt;
    logic           tmo;
    logic [AW+9:0]  mem;
  } stat_t;
  typedef struct {
    int         cyc;
    logic [2:0] rv;
    logic [7:0] data;
    bit         known;
  } rsp_t;
  stat_t sq[$];
  rsp_t  rq[$];

  // Reference model. A holder of -1 means no requester currently owns the port.
  int         m_holder, m_gap, m_idle, m_last, m_pend;
  bit [2:0]   m_blk;
  bit         m_tmo;
  logic [7:0] m_pend_data;
  bit         m_pend_known;
  logic [7:0] shadow [1024];
  bit         shadow_ok [1024];
  logic [2:0] p_req;
  bit         e_en, e_we;
  logic [AW-1:0] e_addr;
  logic [7:0]    e_wd;

  task automatic model_reset();
    m_holder = -1; m_gap = 0; m_idle = 0; m_last = 2; m_pend = -1;
    m_blk = '0; m_tmo = 1'b0; e_en = 1'b0; e_we = 1'b0;
  endtask

  // Apply the previous cycle's inputs to the model state.
  task automatic model_advance();
    int newblk;
    newblk = -1;
    m_pend = -1;
    if (e_en) begin
      if (e_we) begin
        shadow[e_addr] = e_wd;
        shadow_ok[e_addr] = 1'b1;
      end else begin
        m_pend = m_holder;
        m_pend_data = shadow[e_addr];
        m_pend_known = shadow_ok[e_addr];
      end
    end
    m_tmo = 1'b0;
    if (m_holder >= 0) begin
      if (!p_req[m_holder]) begin
        m_last = m_holder; m_holder = -1; m_gap = 1;
      end else if (m_idle == int'(TMO)) begin
        m_tmo = 1'b1; newblk = m_holder; m_last = m_holder; m_holder = -1; m_gap = 1;
      end else begin
        m_idle = e_en ? 0 : m_idle + 1;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      for (int i = 1; i <= 3; i++) begin
        int c;
        c = (m_last + i) % 3;
        if (p_req[c] && !m_blk[c]) begin
          m_holder = c; m_idle = 0;
          break;
        end
      end
    end
    m_blk = m_blk & p_req;
    if (newblk >= 0) m_blk[newblk] = 1'b1;
  endtask

  task automatic model_emit(input logic [2:0] req, input logic [2:0] acc,
                            input logic [2:0] we, input logic [3*AW-1:0] addr,
                            input logic [23:0] wd);
    stat_t s;
    rsp_t  r;
    s.tmo = m_tmo; s.gnt = '0;
    e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
    if (m_holder >= 0) begin
      s.gnt = 3'b001 << m_holder;
      if (req[m_holder]) begin
        e_addr = addr[m_holder*AW +: AW];
        e_wd   = wd[m_holder*8 +: 8];
        e_en   = acc[m_holder];
        e_we   = acc[m_holder] & we[m_holder];
      end
    end
    s.mem = {e_en, e_we, e_addr, e_wd};
    sq.push_back(s);
    if (m_pend >= 0) begin
      r.cyc = cyc; r.rv = 3'b001 << m_pend; r.data = m_pend_data; r.known = m_pend_known;
      rq.push_back(r);
    end
    p_req = req;
  endtask

  task automatic step(input bit rst, input logic [2:0] req, input logic [2:0] acc,
                      input logic [2:0] we, input logic [3*AW-1:0] addr,
                      input logic [23:0] wd);
    @(posedge i_clk);
    #1;
    if (i_rst) model_reset();
    else       model_advance();
    i_rst = rst;
    bus.i_req = req; bus.i_acc = acc; bus.i_we = we; bus.i_addr = addr; bus.i_wdata = wd;
    if (rst) model_reset();
    model_emit(req, acc, we, addr, wd);
  endtask

  task automatic hold(input logic [2:0] req, input int n);
    for (int i = 0; i < n; i++) step(1'b0, req, 3'b000, 3'b000, '0, '0);
  endtask

  task automatic wait_grant(input int n, input logic [2:0] req);
    int k;
    k = 0;
    do begin
      step(1'b0, req, 3'b000, 3'b000, '0, '0);
      k++;
    end while (m_holder != n && k < 12);
    if (m_holder != n) chk("grant_wait", 64'(m_holder), 64'(n));
  endtask

  function automatic logic [3*AW-1:0] ad(input int n, input logic [AW-1:0] a);
    logic [3*AW-1:0] v;
    v = '0;
    v[n*AW +: AW] = a;
    return v;
  endfunction

  function automatic logic [23:0] wdp(input int n, input logic [7:0] d);
    logic [23:0] v;
    v = '0;
    v[n*8 +: 8] = d;
    return v;
  endfunction

  // Monitor: one status entry is consumed per cycle; read responses are consumed on o_rvalid.
  stat_t mon_s;
  rsp_t  mon_r;
  always @(negedge i_clk) begin
    if (sq.size() != 0) begin
      mon_s = sq.pop_front();
      chk("gnt", 64'(bus.o_gnt), 64'(mon_s.gnt));
      chk("timeout", 64'(bus.o_timeout), 64'(mon_s.tmo));
      chk("mem_bus", 64'({bus.o_mem_en, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata}),
          64'(mon_s.mem));
    end
    if (bus.o_rvalid != 3'b000) begin
      if (rq.size() == 0) begin
        chk("unexpected_rvalid", 64'(bus.o_rvalid), 64'd0);
      end else begin
        mon_r = rq.pop_front();
        chk("rvalid", 64'(bus.o_rvalid), 64'(mon_r.rv));
        if (mon_r.known) chk("rdata", 64'(bus.o_rdata), 64'(mon_r.data));
      end
    end else if (rq.size() != 0 && rq[0].cyc <= cyc) begin
      mon_r = rq.pop_front();
      chk("missing_rvalid", 64'(bus.o_rvalid), 64'(mon_r.rv));
    end
  end

  logic [2:0]      r_req, r_acc, r_we;
  logic [3*AW-1:0] r_addr;
  int              rate;

  initial begin
    bus.i_req = '0; bus.i_acc = '0; bus.i_we = '0; bus.i_addr = '0; bus.i_wdata = '0;
    model_reset();
    p_req = '0;
    #1 i_rst = 1'b1;
    #1;
    chk("reset_gnt", 64'(bus.o_gnt), 64'd0);
    chk("reset_rvalid", 64'(bus.o_rvalid), 64'd0);
    chk("reset_timeout", 64'(bus.o_timeout), 64'd0);
    chk("reset_mem_en", 64'(bus.o_mem_en), 64'd0);
    step(1'b1, 3'b000, 3'b000, 3'b000, '0, '0);
    step(1'b1, 3'b000, 3'b000, 3'b000, '0, '0);

    // All three request after reset: the grant rotates 0, 1, 2.
    wait_grant(0, 3'b111);
    hold(3'b111, 2);
    wait_grant(1, 3'b110);
    hold(3'b110, 1);
    wait_grant(2, 3'b100);
    hold(3'b000, 3);

    // Owner 1 writes 0xA5 to address 9, then reads it back.
    wait_grant(1, 3'b010);
    step(1'b0, 3'b010, 3'b010, 3'b010, ad(1, 10'h009), wdp(1, 8'hA5));
    step(1'b0, 3'b010, 3'b010, 3'b000, ad(1, 10'h009), '0);
    step(1'b0, 3'b010, 3'b000, 3'b000, '0, '0);
    hold(3'b000, 3);

    // Requester 2 strobes while owner 0 holds the grant.
    wait_grant(0, 3'b001);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 3'b101, (i % 2 == 1) ? 3'b100 : 3'b101, 3'b000,
           ad(0, 10'(i)) | ad(2, 10'h009), '0);
    end
    hold(3'b000, 3);

    // Owner 0 idles until it times out, then requester 1 is granted.
    wait_grant(0, 3'b001);
    hold(3'b011, 14);
    hold(3'b000, 3);

    // Final read and release of i_req happen back to back.
    wait_grant(1, 3'b010);
    step(1'b0, 3'b010, 3'b010, 3'b000, ad(1, 10'h009), '0);
    hold(3'b000, 4);

    // Reset arrives in the middle of a read cycle.
    wait_grant(2, 3'b100);
    step(1'b0, 3'b100, 3'b100, 3'b000, ad(2, 10'h009), '0);
    #6 i_rst = 1'b1;
    #1;
    chk("rst_abort_gnt", 64'(bus.o_gnt), 64'd0);
    chk("rst_abort_mem_en", 64'(bus.o_mem_en), 64'd0);
    step(1'b1, 3'b111, 3'b000, 3'b000, '0, '0);
    wait_grant(0, 3'b111);
    hold(3'b111, 2);

    // Random traffic. The access rate changes every 200 cycles so that some
    // phases contain timeouts.
    r_req = '0;
    for (int i = 0; i < 3000; i++) begin
      rate = (i / 200) % 4;
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(9) == 0) r_req[b] = ~r_req[b];
        r_acc[b] = ($urandom_range(3) < rate);
        r_we[b]  = 1'($urandom_range(1));
        r_addr[b*AW +: AW] = ($urandom_range(3) == 0) ? AW'($urandom) : AW'($urandom_range(15));
      end
      step(1'b0, r_req, r_acc, r_we, r_addr, 24'($urandom));
    end
    hold(3'b000, 4);
    @(negedge i_clk);
    #1;
    chk("pending_rvalid", 64'(rq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
